// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: bundle between the core datapath/hazard unit and the
// pipeline register chain.
//   master : datapath + hazard unit side (drives payload, stall, flush, clear)
//   slave  : the register chain (drives stage contents, ready, hold, counter)
interface pipe_stage_chain_if #(
    parameter int N_STAGES = 4,
    parameter int WIDTH    = 160,
    parameter int CNT_W    = 16
);
    logic [WIDTH-1:0]          in_data;
    logic                      in_valid;
    logic [N_STAGES-1:0]       stage_stall;
    logic [N_STAGES-1:0]       stage_flush;
    logic                      cnt_clr;
    logic                      in_ready;
    logic [N_STAGES*WIDTH-1:0] stage_data;
    logic [N_STAGES-1:0]       stage_valid;
    logic [N_STAGES-1:0]       stage_hold;
    logic [CNT_W-1:0]          bubble_cnt;

    modport master (
        output in_data, in_valid, stage_stall, stage_flush, cnt_clr,
        input  in_ready, stage_data, stage_valid, stage_hold, bubble_cnt
    );

    modport slave (
        input  in_data, in_valid, stage_stall, stage_flush, cnt_clr,
        output in_ready, stage_data, stage_valid, stage_hold, bubble_cnt
    );
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: chain of N_STAGES pipeline registers with per-stage stall
// and flush, bubble insertion on a free stage behind a frozen one, and a
// saturating bubble counter.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all stages and the counter
//   bus   : pipe_stage_chain_if.slave
//           in_data/in_valid      payload entering stage 0
//           stage_stall/flush     per-stage hold / kill requests
//           cnt_clr               synchronous clear of bubble_cnt
//           in_ready              stage 0 accepts this cycle (~hold[0])
//           stage_data/valid      stage k at [k*WIDTH +: WIDTH] / bit k
//           stage_hold            effective hold per stage
//           bubble_cnt            bubbles inserted, saturating

// One pipeline register. FIRST selects the stage-0 load rule (no bubble).
module pipe_stage_reg #(
    parameter int WIDTH      = 160,
    parameter bit FIRST      = 1'b0,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             hold,
    input  logic             hold_up,   // upstream stage frozen this cycle
    input  logic [WIDTH-1:0] src_data,
    input  logic             src_valid,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             bubble    // rule "free behind frozen" fires
);
    assign bubble = !FIRST && !flush && !hold && hold_up;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data  <= '0;
            valid <= 1'b0;
        end else if (flush) begin
            valid <= 1'b0;
            if (CLEAR_DATA) data <= '0;
        end else if (hold) begin
            data  <= data;
            valid <= valid;
        end else if (FIRST) begin
            data  <= src_data;
            valid <= src_valid;
        end else if (hold_up) begin
            valid <= 1'b0;
            if (CLEAR_DATA) data <= '0;
        end else begin
            data  <= src_data;
            valid <= src_valid;
        end
    end
endmodule

module pipe_stage_chain #(
    parameter int N_STAGES   = 4,
    parameter int WIDTH      = 160,
    parameter bit CLEAR_DATA = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipe_stage_chain_if.slave     bus
);
    logic [N_STAGES-1:0]            hold;
    logic [N_STAGES-1:0]            bubble;
    logic [N_STAGES-1:0]            vld_q;
    logic [N_STAGES-1:0][WIDTH-1:0] data_q;
    logic [CNT_W-1:0]               cnt_q;

    // A stall freezes its own stage and everything upstream of it.
    for (genvar k = 0; k < N_STAGES; k++) begin : g_hold
        assign hold[k] = |bus.stage_stall[N_STAGES-1:k];
    end

    for (genvar k = 0; k < N_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_stage_reg #(.WIDTH(WIDTH), .FIRST(1'b1), .CLEAR_DATA(CLEAR_DATA)) u_reg (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (bus.stage_flush[0]),
                .hold      (hold[0]),
                .hold_up   (1'b0),
                .src_data  (bus.in_data),
                .src_valid (bus.in_valid),
                .data      (data_q[0]),
                .valid     (vld_q[0]),
                .bubble    (bubble[0])
            );
        end else begin : g_rest
            // Source is the pre-flush contents of stage k-1.
            pipe_stage_reg #(.WIDTH(WIDTH), .FIRST(1'b0), .CLEAR_DATA(CLEAR_DATA)) u_reg (
                .clk       (clk),
                .rst_n     (rst_n),
                .flush     (bus.stage_flush[k]),
                .hold      (hold[k]),
                .hold_up   (hold[k-1]),
                .src_data  (data_q[k-1]),
                .src_valid (vld_q[k-1]),
                .data      (data_q[k]),
                .valid     (vld_q[k]),
                .bubble    (bubble[k])
            );
        end
    end

    // At most one count per cycle regardless of how many stages bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (bus.cnt_clr)
            cnt_q <= '0;
        else if (|bubble && cnt_q != {CNT_W{1'b1}})
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.in_ready    = ~hold[0];
    assign bus.stage_hold  = hold;
    assign bus.stage_data  = data_q;
    assign bus.stage_valid = vld_q;
    assign bus.bubble_cnt  = cnt_q;
endmodule

// File: tb/tb_pipe_stage_chain.sv
// tb_pipe_stage_chain: directed checks of pipe_stage_chain.
//   ua: default config (4 stages, 160-bit, CLEAR_DATA=1, CNT_W=16)
//   ub: 4 stages, 32-bit, CLEAR_DATA=0, CNT_W=4 (keep-data flush, saturation)
module tb_pipe_stage_chain;
    localparam int N  = 4;
    localparam int WA = 160;
    localparam int WB = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_stage_chain_if #(.N_STAGES(N), .WIDTH(WA), .CNT_W(16)) ia ();
    pipe_stage_chain_if #(.N_STAGES(N), .WIDTH(WB), .CNT_W(4))  ib ();

    pipe_stage_chain #(.N_STAGES(N), .WIDTH(WA), .CLEAR_DATA(1'b1), .CNT_W(16)) ua (
        .clk (clk), .rst_n (rst_n), .bus (ia.slave)
    );
    pipe_stage_chain #(.N_STAGES(N), .WIDTH(WB), .CLEAR_DATA(1'b0), .CNT_W(4)) ub (
        .clk (clk), .rst_n (rst_n), .bus (ib.slave)
    );

    task automatic chk(input string tag, input logic [WA-1:0] obs, input logic [WA-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WA-1:0] da(input int k);
        return ia.stage_data[k*WA +: WA];
    endfunction

    function automatic logic [WB-1:0] db(input int k);
        return ib.stage_data[k*WB +: WB];
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ia.in_data = '0; ia.in_valid = 1'b0; ia.stage_stall = '0; ia.stage_flush = '0; ia.cnt_clr = 1'b0;
        ib.in_data = '0; ib.in_valid = 1'b0; ib.stage_stall = '0; ib.stage_flush = '0; ib.cnt_clr = 1'b0;
        #2;
        chk("rst_valid", ia.stage_valid, 0);
        chk("rst_data",  ia.stage_data,  0);
        chk("rst_cnt",   ia.bubble_cnt,  0);
        chk("rst_ready", ia.in_ready,    1);
        #10 rst_n = 1'b1;

        // Stream 1..5, no stalls: stage 3 sees 1 after the 4th edge.
        ia.in_valid = 1'b1;
        ia.in_data = 1; tick();
        chk("s1_stage0", da(0), 1);
        ia.in_data = 2; tick();
        ia.in_data = 3; tick();
        ia.in_data = 4; tick();
        chk("s1_stage3_e4", da(3), 1);
        chk("s1_valid3",    ia.stage_valid[3], 1);
        ia.in_data = 5; tick();
        chk("s1_stage3_e5", da(3), 2);
        chk("s1_cnt",       ia.bubble_cnt, 0);

        // Load-use stall on stage 1 (s1=4, s0=5): bubble into stage 2.
        ia.stage_stall = 4'b0010; ia.in_data = 6; #1;
        chk("s2_ready", ia.in_ready,   0);
        chk("s2_hold",  ia.stage_hold, 4'b0011);
        tick();
        chk("s2_stage0", da(0), 5);
        chk("s2_stage1", da(1), 4);
        chk("s2_bub_d",  da(2), 0);
        chk("s2_bub_v",  ia.stage_valid[2], 0);
        chk("s2_stage3", da(3), 3);
        chk("s2_cnt",    ia.bubble_cnt, 1);
        ia.stage_stall = '0; tick();
        chk("s2_resume0", da(0), 6);
        chk("s2_resume2", da(2), 4);
        chk("s2_bub_v3",  ia.stage_valid[3], 0);

        // Branch taken: flush 0,1 with stall 0; stage 2 takes old stage 1 (5).
        ia.stage_flush = 4'b0011; ia.stage_stall = 4'b0001; ia.in_data = 7; tick();
        chk("s3_valid", ia.stage_valid, 4'b1100);
        chk("s3_data0", da(0), 0);
        chk("s3_data2", da(2), 5);
        chk("s3_data3", da(3), 4);
        chk("s3_cnt",   ia.bubble_cnt, 1);
        ia.stage_flush = '0; ia.stage_stall = '0; ia.in_valid = 1'b0; ia.in_data = 0; tick();
        chk("s3_drain_d3", da(3), 5);
        chk("s3_drain_v",  ia.stage_valid, 4'b1000);

        // Stall stage 2 -> bubble into stage 3, then async reset mid-cycle.
        ia.in_data = 9; ia.in_valid = 1'b1; ia.stage_stall = 4'b0100; tick();
        chk("s6_cnt_pre", ia.bubble_cnt, 2);
        chk("s6_v3_pre",  ia.stage_valid[3], 0);
        #3 rst_n = 1'b0;
        #1;
        chk("s6_valid", ia.stage_valid, 0);
        chk("s6_data",  ia.stage_data,  0);
        chk("s6_cnt",   ia.bubble_cnt,  0);
        tick();
        rst_n = 1'b1;
        ia.in_data = 0; ia.in_valid = 1'b0; ia.stage_stall = '0;

        // CLEAR_DATA=0: flushing stage 2 keeps its payload.
        ib.in_data = 32'hDEADBEEF; ib.in_valid = 1'b1; tick();
        ib.in_data = 0; ib.in_valid = 1'b0; tick(); tick();
        chk("s4_pre_d2", db(2), 32'hDEADBEEF);
        chk("s4_pre_v2", ib.stage_valid[2], 1);
        ib.stage_flush = 4'b0100; tick();
        chk("s4_v2",    ib.stage_valid[2], 0);
        chk("s4_d2",    db(2), 32'hDEADBEEF);
        chk("s4_d3",    db(3), 32'hDEADBEEF);
        chk("s4_v3",    ib.stage_valid[3], 1);
        ib.stage_flush = '0;

        // CNT_W=4: 20 bubbles saturate at 15; clear beats increment.
        ib.stage_stall = 4'b0001;
        repeat (20) tick();
        chk("s5_sat",   ib.bubble_cnt, 15);
        chk("s5_hold",  ib.stage_hold, 4'b0001);
        ib.cnt_clr = 1'b1; tick();
        chk("s5_clr",   ib.bubble_cnt, 0);
        ib.cnt_clr = 1'b0; tick();
        chk("s5_inc",   ib.bubble_cnt, 1);
        ib.stage_stall = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
